// File: rtl/fwd_hazard_unit.sv
//==============================================================================
// fwd_hazard_unit : EX operand forwarding + load-use stall (optional macro FWD_ZERO_REG_EN)
// Rev 1.0
//==============================================================================
`default_nettype none

module fwd_hazard_unit #(
  parameter int REG_AW = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_b_imm,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic [DW-1:0]     ex_result,
  input  logic [DW-1:0]     mem_rdata,
  output logic              stall,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DW-1:0]     fwd_data_a,
  output logic [DW-1:0]     fwd_data_b
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M    = 2'd1,
    SEL_W    = 2'd2
  } sel_t;

  logic              e_valid_q, e_valid_d;
  logic              e_we_q, e_we_d;
  logic [REG_AW-1:0] e_rd_q, e_rd_d;
  logic              e_is_load_q, e_is_load_d;
  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [REG_AW-1:0] m_rd_q, m_rd_d;
  logic              m_is_load_q, m_is_load_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  sel_t              sel_a_q, sel_a_d;
  sel_t              sel_b_q, sel_b_d;

  logic e_match_a, e_match_b, m_match_a, m_match_b;

  function automatic logic slot_match(input logic v, input logic we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
`ifdef FWD_ZERO_REG_EN
    return v & we & (rd == r) & (rd != '0);
`else
    return v & we & (rd == r);
`endif
  endfunction

  always_comb begin
    e_match_a = slot_match(e_valid_q, e_we_q, e_rd_q, id_ra);
    e_match_b = slot_match(e_valid_q, e_we_q, e_rd_q, id_rb);
    m_match_a = slot_match(m_valid_q, m_we_q, m_rd_q, id_ra);
    m_match_b = slot_match(m_valid_q, m_we_q, m_rd_q, id_rb);

    stall = id_valid & e_is_load_q & (e_match_a | (~id_b_imm & e_match_b));

    e_valid_d   = id_valid & ~stall;
    e_we_d      = id_we;
    e_rd_d      = id_rd;
    e_is_load_d = id_is_load;

    m_valid_d   = e_valid_q;
    m_we_d      = e_we_q;
    m_rd_d      = e_rd_q;
    m_is_load_d = e_is_load_q;
    m_data_d    = ex_result;
    w_data_d    = m_is_load_q ? mem_rdata : m_data_q;

    // Selects are named by where the producer will sit when the consumer reaches EX.
    // A matching load in E never reaches here: it has already raised stall.
    sel_a_d = SEL_NONE;
    sel_b_d = SEL_NONE;
    if (id_valid && !stall) begin
      if (e_match_a)      sel_a_d = SEL_M;
      else if (m_match_a) sel_a_d = SEL_W;
      if (!id_b_imm) begin
        if (e_match_b)      sel_b_d = SEL_M;
        else if (m_match_b) sel_b_d = SEL_W;
      end
    end
  end

  // WB-stage tags are not kept: the register file already serves that producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q   <= 1'b0;
      e_we_q      <= 1'b0;
      e_rd_q      <= '0;
      e_is_load_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_we_q      <= 1'b0;
      m_rd_q      <= '0;
      m_is_load_q <= 1'b0;
      m_data_q    <= '0;
      w_data_q    <= '0;
      sel_a_q     <= SEL_NONE;
      sel_b_q     <= SEL_NONE;
    end else begin
      e_valid_q   <= e_valid_d;
      e_we_q      <= e_we_d;
      e_rd_q      <= e_rd_d;
      e_is_load_q <= e_is_load_d;
      m_valid_q   <= m_valid_d;
      m_we_q      <= m_we_d;
      m_rd_q      <= m_rd_d;
      m_is_load_q <= m_is_load_d;
      m_data_q    <= m_data_d;
      w_data_q    <= w_data_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
    end
  end

  assign fwd_a      = (sel_a_q != SEL_NONE);
  assign fwd_b      = (sel_b_q != SEL_NONE);
  assign fwd_data_a = (sel_a_q == SEL_M) ? m_data_q : w_data_q;
  assign fwd_data_b = (sel_b_q == SEL_M) ? m_data_q : w_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
//==============================================================================
// tb_fwd_hazard_unit : directed vectors checked against an issue-history model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_b_imm, id_we, id_is_load;
  logic [3:0]  id_ra, id_rb, id_rd;
  logic [31:0] ex_result, mem_rdata;
  logic        stall, fwd_a, fwd_b;
  logic [31:0] fwd_data_a, fwd_data_b;

  fwd_hazard_unit #(.REG_AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb), .id_b_imm(id_b_imm),
    .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load),
    .ex_result(ex_result), .mem_rdata(mem_rdata),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit reset_hit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // History of what ID presented each cycle and which instructions were accepted.
  typedef struct {
    logic       v, we, ld, imm;
    logic [3:0] ra, rb, rd;
  } instr_t;

  instr_t      idl [0:511];
  logic [31:0] exr [0:511];
  logic [31:0] mrd [0:511];
  bit          acc [0:511];
  int          k = 0;

  function automatic instr_t accepted(input int i);
    instr_t b;
    b = '{v:1'b0, we:1'b0, ld:1'b0, imm:1'b0, ra:4'd0, rb:4'd0, rd:4'd0};
    if (i < 0 || !acc[i]) return b;
    return idl[i];
  endfunction

  function automatic logic writes(input instr_t p, input logic [3:0] r);
`ifdef FWD_ZERO_REG_EN
    return p.v & p.we & (p.rd == r) & (r != 4'd0);
`else
    return p.v & p.we & (p.rd == r);
`endif
  endfunction

  // Value the consumer now in EX should see on source r, from the two older producers.
  task automatic expect_src(input instr_t p1, input instr_t p2, input logic [3:0] r,
                            output logic f, output logic [31:0] val);
    f = 1'b0; val = 32'h0;
    if (writes(p1, r)) begin
      f = ~p1.ld; val = exr[k-1];
    end else if (writes(p2, r)) begin
      f = 1'b1; val = p2.ld ? mrd[k-1] : exr[k-2];
    end
  endtask

  always @(negedge clk) begin
    instr_t cur, e, cons, p1, p2;
    logic st, fa, fb;
    logic [31:0] va, vb;
    cur = '{v:id_valid, we:id_we, ld:id_is_load, imm:id_b_imm, ra:id_ra, rb:id_rb, rd:id_rd};
    idl[k] = cur; exr[k] = ex_result; mrd[k] = mem_rdata;
    if (!rst_n || reset_hit) begin
      for (int i = k - 3; i < k; i++) if (i >= 0) acc[i] = 1'b0;
      reset_hit = 1'b0;
    end
    e  = accepted(k-1);
    st = cur.v & e.ld & (writes(e, cur.ra) | (~cur.imm & writes(e, cur.rb)));
    acc[k] = rst_n & cur.v & ~st;
    cons = accepted(k-1);
    p1   = accepted(k-2);
    p2   = accepted(k-3);
    fa = 1'b0; fb = 1'b0; va = 0; vb = 0;
    if (cons.v) begin
      expect_src(p1, p2, cons.ra, fa, va);
      if (!cons.imm) expect_src(p1, p2, cons.rb, fb, vb);
    end
    chk("model_stall", {31'd0, stall}, {31'd0, st});
    chk("model_fwd_a", {31'd0, fwd_a}, {31'd0, fa});
    chk("model_fwd_b", {31'd0, fwd_b}, {31'd0, fb});
    if (fa) chk("model_data_a", fwd_data_a, va);
    if (fb) chk("model_data_b", fwd_data_b, vb);
    k++;
  end

  task automatic step(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                      input logic imm, input logic we, input logic [3:0] rd,
                      input logic ld, input logic [31:0] exv, input logic [31:0] mv);
    @(posedge clk); #1;
    id_valid = v; id_ra = ra; id_rb = rb; id_b_imm = imm;
    id_we = we; id_rd = rd; id_is_load = ld;
    ex_result = exv; mem_rdata = mv;
  endtask

  task automatic nop(input logic [31:0] exv);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, exv, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_ra = 0; id_rb = 0; id_b_imm = 0; id_we = 0; id_rd = 0;
    id_is_load = 0; ex_result = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #6;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    nop(0); nop(0);

    // add r1 ; add r2,r1,r3 : result 5 forwarded from M with no stall
    step(1, 4'd2, 4'd3, 0, 1, 4'd1, 0, 32'h0, 0);       #5 chk("t1_stall0", {31'd0, stall}, 0);
    step(1, 4'd1, 4'd3, 0, 1, 4'd2, 0, 32'h5, 0);       #5 chk("t1_stall1", {31'd0, stall}, 0);
    nop(32'h9);                                          #5;
    chk("t1_fwd_a", {31'd0, fwd_a}, 1); chk("t1_data_a", fwd_data_a, 32'h5);
    chk("t1_stall2", {31'd0, stall}, 0);
    nop(0); nop(0);

    // r4 producer, independent instr, consumer of r4 on B via W
    step(1, 4'd12, 4'd13, 0, 1, 4'd4, 0, 32'h0, 0);
    step(1, 4'd14, 4'd15, 0, 1, 4'd11, 0, 32'h44, 0);
    step(1, 4'd14, 4'd4, 0, 1, 4'd10, 0, 32'h99, 0);
    nop(32'h3);                                          #5;
    chk("t2_fwd_b", {31'd0, fwd_b}, 1); chk("t2_data_b", fwd_data_b, 32'h44);
    nop(0); nop(0);

    // ld r5 ; add r6,r5,r5 : one bubble, then both operands from W
    step(1, 4'd12, 4'd13, 0, 1, 4'd5, 1, 32'h0, 0);
    step(1, 4'd5, 4'd5, 0, 1, 4'd6, 0, 32'h100, 0);      #5 chk("t3_stall", {31'd0, stall}, 1);
    step(1, 4'd5, 4'd5, 0, 1, 4'd6, 0, 32'h0, 32'hDEADBEEF); #5 chk("t3_unstall", {31'd0, stall}, 0);
    nop(32'h7);                                          #5;
    chk("t3_fwd", {30'd0, fwd_a, fwd_b}, 32'd3);
    chk("t3_data_a", fwd_data_a, 32'hDEADBEEF); chk("t3_data_b", fwd_data_b, 32'hDEADBEEF);
    nop(0); nop(0);

    // rb=r7 immediate while load r7 in E : no stall, no B forward
    step(1, 4'd12, 4'd13, 0, 1, 4'd7, 1, 32'h0, 0);
    step(1, 4'd12, 4'd7, 1, 1, 4'd6, 0, 32'h200, 0);     #5 chk("t4_stall", {31'd0, stall}, 0);
    nop(0);                                              #5 chk("t4_fwd_b", {31'd0, fwd_b}, 0);
    nop(0); nop(0);

    // r8 written by M (1) and E (2) : newest wins
    step(1, 4'd12, 4'd13, 0, 1, 4'd8, 0, 32'h0, 0);
    step(1, 4'd12, 4'd13, 0, 1, 4'd8, 0, 32'h1, 0);
    step(1, 4'd8, 4'd13, 0, 1, 4'd9, 0, 32'h2, 0);
    nop(32'h5);                                          #5;
    chk("t5_fwd_a", {31'd0, fwd_a}, 1); chk("t5_data_a", fwd_data_a, 32'h2);
    nop(0); nop(0);

    // write r0 then read r0
    step(1, 4'd12, 4'd13, 0, 1, 4'd0, 0, 32'h0, 0);
    step(1, 4'd0, 4'd15, 0, 1, 4'd9, 0, 32'h77, 0);
    nop(0);                                              #5;
`ifdef FWD_ZERO_REG_EN
    chk("t6_fwd_a_r0", {31'd0, fwd_a}, 0);
`else
    chk("t6_fwd_a_r0", {31'd0, fwd_a}, 1); chk("t6_data_a", fwd_data_a, 32'h77);
`endif
    nop(0); nop(0);

    // reset pulse in the middle of a load-use stall
    step(1, 4'd12, 4'd13, 0, 1, 4'd9, 1, 32'h0, 0);
    step(1, 4'd9, 4'd13, 0, 1, 4'd10, 0, 32'h300, 0);
    #1 chk("t7_stall_pre", {31'd0, stall}, 1);
    rst_n = 1'b0;
    #1 chk("t7_stall_rst", {31'd0, stall}, 0);
    chk("t7_fwd_rst", {30'd0, fwd_a, fwd_b}, 0);
    chk("t7_data_rst", fwd_data_a | fwd_data_b, 0);
    rst_n = 1'b1; reset_hit = 1'b1;
    nop(0); nop(0); nop(0); nop(0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
